// File: rtl/pc_unit.sv
// Program-counter unit: holds the fetch PC and picks the next one (sequential, branch, jump, stall).
// Define PC_RAS_EN to add call/ret handling through a circular return-address stack.
module pc_unit #(
  parameter int                ADDR_W       = 32,
  parameter int                INSTR_BYTES  = 4,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
`ifdef PC_RAS_EN
  , parameter int              RAS_DEPTH    = 4
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
`ifdef PC_RAS_EN
  input  logic              call,
  input  logic              ret,
  output logic              ras_empty,
`endif
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus,
  output logic              fetch_valid,
  output logic              misalign_err
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INSTR_BYTES - 1);
  localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(INSTR_BYTES);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              fetch_valid_q, fetch_valid_d;
  logic              misalign_q, misalign_d;
  logic [ADDR_W-1:0] target;
  logic              take_target;

`ifdef PC_RAS_EN
  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  // The occupancy counter is wider than the storage, so pops past a wrap replay overwritten slots.
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] ras_mem_q [RAS_DEPTH];
  logic [ADDR_W-1:0] ras_mem_d [RAS_DEPTH];
  logic [PTR_W-1:0]  ras_ptr_q, ras_ptr_d, ras_top_idx;
  logic [CNT_W-1:0]  ras_cnt_q, ras_cnt_d;
  logic              push_req, ras_push, ras_pop;

  assign ras_empty   = (ras_cnt_q == '0);
  assign ras_top_idx = (ras_ptr_q == '0) ? PTR_W'(RAS_DEPTH - 1) : ras_ptr_q - PTR_W'(1);

  always_comb begin
    ras_mem_d = ras_mem_q;
    ras_ptr_d = ras_ptr_q;
    ras_cnt_d = ras_cnt_q;
    if (ras_push) begin
      ras_mem_d[ras_ptr_q] = pc_plus;
      ras_ptr_d = (ras_ptr_q == PTR_W'(RAS_DEPTH - 1)) ? '0 : ras_ptr_q + PTR_W'(1);
      if (ras_cnt_q != '1) begin
        ras_cnt_d = ras_cnt_q + CNT_W'(1);
      end
    end else if (ras_pop) begin
      ras_ptr_d = ras_top_idx;
      ras_cnt_d = ras_cnt_q - CNT_W'(1);
    end
  end
`endif

  assign pc_plus = pc_q + STEP;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    misalign_d  = misalign_q;
    target      = '0;
    take_target = 1'b0;
`ifdef PC_RAS_EN
    push_req    = 1'b0;
    ras_push    = 1'b0;
    ras_pop     = 1'b0;
`endif
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (stall) begin
          pc_d = pc_q;
        end
`ifdef PC_RAS_EN
        else if (ret) begin
          if (ras_empty) begin
            misalign_d = 1'b1;
            state_d    = HALT;
          end else begin
            ras_pop = 1'b1;
            pc_d    = ras_mem_q[ras_top_idx];
          end
        end
        else if (call) begin
          target      = jump_target;
          take_target = 1'b1;
          push_req    = 1'b1;
        end
`endif
        else if (jump) begin
          target      = jump_target;
          take_target = 1'b1;
        end
        else if (branch_taken) begin
          target      = branch_target;
          take_target = 1'b1;
        end
        else begin
          pc_d = pc_plus;
        end
        // Only the winning target is alignment-checked; a bad one freezes the unit.
        if (take_target) begin
          if ((target & ALIGN_MASK) != '0) begin
            misalign_d = 1'b1;
            state_d    = HALT;
          end else begin
            pc_d = target;
`ifdef PC_RAS_EN
            ras_push = push_req;
`endif
          end
        end
      end
      default: state_d = HALT;
    endcase
    fetch_valid_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= BOOT;
      pc_q          <= RESET_VECTOR;
      fetch_valid_q <= 1'b0;
      misalign_q    <= 1'b0;
`ifdef PC_RAS_EN
      ras_ptr_q     <= '0;
      ras_cnt_q     <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_mem_q[i] <= '0;
      end
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_valid_q <= fetch_valid_d;
      misalign_q    <= misalign_d;
`ifdef PC_RAS_EN
      ras_ptr_q     <= ras_ptr_d;
      ras_cnt_q     <= ras_cnt_d;
      ras_mem_q     <= ras_mem_d;
`endif
    end
  end

  assign pc           = pc_q;
  assign fetch_valid  = fetch_valid_q;
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: a 32-bit instance (reset vector 0x100) and an 8-bit instance for wrap.
module tb_pc_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0, branch_taken = 1'b0, jump = 1'b0;
  logic [31:0] branch_target = '0, jump_target = '0;
  logic [31:0] pc, pc_plus;
  logic        fetch_valid, misalign_err;

  logic [7:0]  pc8, pc_plus8;
  logic        fetch_valid8, misalign_err8;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

`ifdef PC_RAS_EN
  logic call = 1'b0, ret = 1'b0, ras_empty;
  logic ras_empty8;
`endif

  pc_unit #(
    .ADDR_W(32), .INSTR_BYTES(4), .RESET_VECTOR(32'h100)
`ifdef PC_RAS_EN
    , .RAS_DEPTH(2)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
`ifdef PC_RAS_EN
    .call(call), .ret(ret), .ras_empty(ras_empty),
`endif
    .pc(pc), .pc_plus(pc_plus), .fetch_valid(fetch_valid), .misalign_err(misalign_err)
  );

  pc_unit #(
    .ADDR_W(8), .INSTR_BYTES(4), .RESET_VECTOR(8'hFC)
  ) dut8 (
    .clk(clk), .rst_n(rst_n), .stall(1'b0),
    .branch_taken(1'b0), .branch_target(8'h00),
    .jump(1'b0), .jump_target(8'h00),
`ifdef PC_RAS_EN
    .call(1'b0), .ret(1'b0), .ras_empty(ras_empty8),
`endif
    .pc(pc8), .pc_plus(pc_plus8), .fetch_valid(fetch_valid8), .misalign_err(misalign_err8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset release between edges; BOOT cycle holds the reset vector
    #22 rst_n = 1'b1;
    #1;
    check("reset_pc", pc, 32'h100);
    check("reset_fv", {31'b0, fetch_valid}, 32'd0);
    check("reset_err", {31'b0, misalign_err}, 32'd0);
    check("reset_pc8", {24'b0, pc8}, 32'hFC);
`ifdef PC_RAS_EN
    check("reset_ras_empty", {31'b0, ras_empty}, 32'd1);
`endif
    tick();
    check("run_pc", pc, 32'h100);
    check("run_fv", {31'b0, fetch_valid}, 32'd1);
    check("run_pc8", {24'b0, pc8}, 32'hFC);
    tick();
    check("seq_pc1", pc, 32'h104);
    check("wrap_pc8", {24'b0, pc8}, 32'h00);
    check("wrap_err8", {31'b0, misalign_err8}, 32'd0);
    tick();
    check("seq_pc2", pc, 32'h108);

    // Jump beats branch
    jump = 1'b1; jump_target = 32'h200;
    tick();
    check("jump_200", pc, 32'h200);
    jump_target = 32'h400; branch_taken = 1'b1; branch_target = 32'h300;
    tick();
    check("jump_over_branch", pc, 32'h400);
    branch_taken = 1'b0;

    // Stall drops a concurrent branch
    jump_target = 32'h10;
    tick();
    check("jump_10", pc, 32'h10);
    jump = 1'b0;
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h300;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("stall_%0d", i), pc, 32'h10);
    end
    stall = 1'b0; branch_taken = 1'b0;
    tick();
    check("after_stall", pc, 32'h14);

    branch_taken = 1'b1; branch_target = 32'h80;
    tick();
    check("branch_80", pc, 32'h80);

    // Misaligned branch loses to an aligned jump: no error
    jump = 1'b1; jump_target = 32'h500; branch_target = 32'h202;
    tick();
    check("unselected_misalign_pc", pc, 32'h500);
    check("unselected_misalign_err", {31'b0, misalign_err}, 32'd0);
    jump = 1'b0;

`ifdef PC_RAS_EN
    branch_taken = 1'b0;
    jump = 1'b1; jump_target = 32'h0;
    tick();
    check("ras_jump_0", pc, 32'h0);
    jump = 1'b0; call = 1'b1;
    jump_target = 32'h20; tick(); check("call_20", pc, 32'h20);
    check("ras_nonempty", {31'b0, ras_empty}, 32'd0);
    jump_target = 32'h40; tick(); check("call_40", pc, 32'h40);
    jump_target = 32'h60; tick(); check("call_60", pc, 32'h60);
    call = 1'b0; ret = 1'b1;
    tick(); check("ret_1", pc, 32'h44);
    tick(); check("ret_2", pc, 32'h24);
    tick(); check("ret_3", pc, 32'h44);
    check("ras_empty_after", {31'b0, ras_empty}, 32'd1);
    tick();
    check("ret_empty_pc", pc, 32'h44);
    check("ret_empty_err", {31'b0, misalign_err}, 32'd1);
    check("ret_empty_fv", {31'b0, fetch_valid}, 32'd0);
    ret = 1'b0;
    rst_n = 1'b0; #2 rst_n = 1'b1;
    tick();
    tick();
    jump = 1'b1; jump_target = 32'h500;
    tick();
    check("ras_rejoin_pc", pc, 32'h500);
    jump = 1'b0; branch_taken = 1'b1; branch_target = 32'h202;
`else
    branch_taken = 1'b1; branch_target = 32'h202;
`endif

    // Selected misaligned branch halts and sticks
    tick();
    check("misalign_pc", pc, 32'h500);
    check("misalign_err", {31'b0, misalign_err}, 32'd1);
    check("misalign_fv", {31'b0, fetch_valid}, 32'd0);
    branch_taken = 1'b0;
    jump = 1'b1; jump_target = 32'h600;
    tick();
    tick();
    check("halt_pc", pc, 32'h500);
    check("halt_err", {31'b0, misalign_err}, 32'd1);
    check("halt_fv", {31'b0, fetch_valid}, 32'd0);
    jump = 1'b0;

    // Asynchronous reset mid-cycle clears state without a clock edge
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_pc", pc, 32'h100);
    check("async_rst_err", {31'b0, misalign_err}, 32'd0);
    check("async_rst_fv", {31'b0, fetch_valid}, 32'd0);
    #1 rst_n = 1'b1;
    tick();
    check("post_rst_pc", pc, 32'h100);
    check("post_rst_fv", {31'b0, fetch_valid}, 32'd1);
    tick();
    check("post_rst_seq", pc, 32'h104);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
